// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide with architectural HI/LO registers.
// Latency: W+2 cycles from an accepted start to the done pulse (W RUN + 1 FIX + result cycle).
// Backpressure: start is accepted only while idle (busy=0); requests made while busy are dropped.
//
// Ports:
//   clk, reset        - rising-edge clock, asynchronous active-high reset
//   start, op, a, b   - operation request; op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   cancel            - abort the operation in flight (RUN or FIX)
//   mthi, mtlo, wdata - direct HI/LO writes, honoured only while idle
//   busy, done, dz    - status: in flight, one-cycle completion, divide-by-zero (with done)
//   hi, lo            - HI/LO register contents
module muldiv_unit #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cancel,
  input  logic         mthi,
  input  logic         mtlo,
  input  logic [W-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic         dz,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t         state;
  logic           is_div;   // op[0] (signedness) is already folded into the sign bits
  logic           sign_a;
  logic           sign_b;
  logic           div_zero;
  logic [W-1:0]   mag_b;
  logic [2*W-1:0] acc;      // multiply: {partial product, multiplier}; divide: low half is the quotient
  logic [W-1:0]   rem;      // remainder is always < divisor, so W bits hold it between iterations
  logic [CW-1:0]  cnt;

  // Operand magnitudes for the start edge
  logic           signed_op;
  logic           a_neg;
  logic           b_neg;
  logic [W-1:0]   abs_a;
  logic [W-1:0]   abs_b;

  assign signed_op = ~op[0];
  assign a_neg     = signed_op & a[W-1];
  assign b_neg     = signed_op & b[W-1];
  assign abs_a     = a_neg ? -a : a;
  assign abs_b     = b_neg ? -b : b;

  // Shift-add step: conditionally add the multiplicand into the upper half,
  // then shift the whole accumulator right with the carry.
  logic [W:0] mul_sum;
  assign mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mag_b} : {(W+1){1'b0}});

  // Restoring divide step on the W+1-bit shifted partial remainder.
  logic [W:0] div_shift;
  logic [W:0] div_sub;
  logic       div_ge;
  assign div_shift = {rem, acc[W-1]};
  assign div_ge    = (div_shift >= {1'b0, mag_b});
  assign div_sub   = div_shift - {1'b0, mag_b};

  // Sign correction applied in FIX
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix;
  logic [W-1:0]   rem_fix;
  assign prod_fix = (sign_a ^ sign_b) ? -acc : acc;
  assign quo_fix  = (sign_a ^ sign_b) ? -acc[W-1:0] : acc[W-1:0];
  // With a zero divisor the remainder ends up as |a|, so this also yields HI = a.
  assign rem_fix  = sign_a ? -rem : rem;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      is_div   <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
      mag_b    <= '0;
      acc      <= '0;
      rem      <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      dz       <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      dz   <= 1'b0;
      case (state)
        IDLE: begin
          if (mthi) hi <= wdata;
          if (mtlo) lo <= wdata;
          if (start) begin
            state    <= RUN;
            is_div   <= op[1];
            sign_a   <= a_neg;
            sign_b   <= b_neg;
            div_zero <= op[1] && (b == '0);
            mag_b    <= abs_b;
            acc      <= {{W{1'b0}}, abs_a};
            rem      <= '0;
            cnt      <= '0;
          end
        end
        RUN: begin
          if (cancel) begin
            state <= IDLE;
          end else begin
            if (is_div) begin
              rem        <= div_ge ? div_sub[W-1:0] : div_shift[W-1:0];
              acc[W-1:0] <= {acc[W-2:0], div_ge};
            end else begin
              acc <= {mul_sum, acc[W-1:1]};
            end
            cnt <= cnt + 1'b1;
            if (cnt == CW'(W - 1)) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          if (!cancel) begin
            done <= 1'b1;
            dz   <= div_zero;
            if (is_div) begin
              lo <= div_zero ? {W{1'b1}} : quo_fix;
              hi <= rem_fix;
            end else begin
              hi <= prod_fix[2*W-1:W];
              lo <= prod_fix[W-1:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers. It replaces the single-cycle multiplier path that feeds HI/LO in the pipeline CPU. The unit is parametrised in operand width and supports signed and unsigned multiply and divide, cancellation, and direct HI/LO writes. The EXE stage starts an operation and stalls mfhi/mflo on `busy`. Results are visible on `hi`/`lo` in the cycle `done` pulses.

## Interface
- `W`, default 32: operand width; legal values are W >= 2. HI/LO are each W bits.
- `clk`  in  1: rising-edge clock; the block uses one clock only.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: request a new operation. Sampled only in IDLE.
- `op`  in  2: operation code. 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. Sampled with `start`.
- `a`, `b`  in  W: operands. For divides, `a` is the dividend and `b` the divisor. Latched on the `start` edge.
- `cancel`  in  1: abort the operation in flight.
- `mthi`, `mtlo`  in  1: write `wdata` into HI or LO.
- `wdata`  in  W: data for `mthi`/`mtlo`.
- `busy`  out  1: high when the state is not IDLE.
- `done`  out  1: one-cycle pulse when HI/LO have been updated by an operation.
- `dz`  out  1: divide-by-zero flag. Valid only while `done`=1.
- `hi`, `lo`  out  W: the HI/LO register contents, driven directly from the registers.

## Operation
- States: IDLE, RUN, FIX.
- IDLE→RUN on `start`. On that edge:
  - latch `op`;
  - latch the operand magnitudes (|a|, |b| for signed ops, raw values for unsigned);
  - latch the sign bits;
  - clear the iteration counter. The counter is $clog2(W)+1 bits.
- RUN executes one iteration per cycle, for exactly W cycles, then moves to FIX.
- Multiply uses a 2W-bit shift-add on the magnitudes, one multiplier bit per cycle.
- Divide uses a restoring algorithm with a W+1-bit partial remainder, one quotient bit per cycle.
- In FIX (one cycle), the sign correction is applied and written to HI/LO on the edge leaving FIX. The state then returns to IDLE.
  - MULT: the 2W-bit product is negated if the operand signs differ. HI gets the upper W bits, LO the lower W bits.
  - DIV: the quotient is negated if the operand signs differ. The remainder is negated if the dividend is negative. LO gets the quotient, HI the remainder.
  - Unsigned ops: no correction is applied.
- The signed overflow case, DIV of the most negative value by -1, gives LO = most negative value and HI = 0. This is the natural truncation; no flag is raised.
- Divide by zero (`b`==0, DIV or DIVU):
  - full latency is kept;
  - LO = all ones, HI = `a`;
  - `dz`=1 together with `done`.
- `start` while `busy` is ignored. It is not queued.
- `cancel` in RUN or FIX:
  - the state goes to IDLE on the next edge;
  - HI/LO are unchanged and `done` is not asserted;
  - `cancel` overrides completion when it is high in FIX.
- `cancel` in IDLE has no effect.
- `mthi`/`mtlo` in IDLE write on the next edge.
  - They are ignored while `busy`.
  - If `start` is accepted on the same edge, both take effect; the later result overwrites HI/LO.
  - `mthi` and `mtlo` together write both registers.

## Timing
- Reset values:
  - state IDLE;
  - `hi`=0, `lo`=0;
  - `busy`=0, `done`=0, `dz`=0;
  - all datapath registers 0.
- Reset asserted mid-operation aborts the operation immediately with no `done`.
- Cycle numbering: cycle 0 is the cycle in which `start` is sampled high in IDLE.
  - `busy`=1 in cycles 1…W+1 (RUN in cycles 1…W, FIX in cycle W+1).
  - In cycle W+2: `busy`=0, `done`=1, `hi`/`lo` hold the new values.
  - Total latency is W+2 cycles; 34 for W=32.
- Back-to-back operation: a new `start` is accepted in cycle W+2, the same cycle `done` is high.
- `done` and `dz` are registered, high for exactly one cycle, and otherwise 0.
- `cancel` sampled in cycle k (1 ≤ k ≤ W+1) makes `busy`=0 in cycle k+1.
- `a`/`b`/`op` may change freely after cycle 0.

## Test plan
- MULT, W=32, a=0xFFFFFFFE, b=3.
  - Required: `done` in cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFFA, `busy` high in cycles 1–33.
- MULTU, same operands, issued in the `done` cycle of the previous op.
  - Required: hi=0x00000002, lo=0xFFFFFFFA, 34 cycles later.
- DIV -7/2, then DIV 0x80000000 / 0xFFFFFFFF.
  - Required: lo=0xFFFFFFFD and hi=0xFFFFFFFF; then lo=0x80000000 and hi=0, both with `dz`=0.
- DIVU 7/0.
  - Required: `done` in cycle 34 with `dz`=1, lo=0xFFFFFFFF, hi=7. `dz`=0 in cycle 35.
- After mthi 0x1234 and mtlo 0x5678 (`hi`=0x1234, `lo`=0x5678): start MULTU 5×5, raise `cancel` in cycle 10, and pulse `start` in cycle 5 with `mthi` wdata=0xDEAD.
  - Required: `busy`=0 in cycle 11, no `done`, hi=0x1234, lo=0x5678.
- Start DIVU 100/7, then assert `reset` in cycle 20.
  - Required: all outputs 0 immediately. A subsequent DIVU 100/7 gives lo=14, hi=2.
